// File: rtl/daq_fmt_pkg.sv
// -----------------------------------------------------------------------------
// daq_fmt_pkg
// Shared constants and types for the DAQ frame formatter.
//   - K-character words for filler (comma), start-of-frame and end-of-frame
//   - DOUT_K flag patterns for K words and plain data words
//   - header/trailer identifier nibbles
//   - formatter FSM state enum
//   - CRC-16-CCITT polynomial and seed
// Ports: none (package).
// Optional feature macro used by the importing files: DAQFMT_CRC_EN.
// -----------------------------------------------------------------------------
package daq_fmt_pkg;

  // K-character words sent on the GTX path
  localparam logic [15:0] K_IDLE  = 16'h50BC;
  localparam logic [15:0] K_SOF   = 16'hFBFB;
  localparam logic [15:0] K_EOF   = 16'hFDFD;

  // DOUT_K patterns: [1] flags DOUT[15:8], [0] flags DOUT[7:0]
  localparam logic [1:0]  KF_IDLE = 2'b01;
  localparam logic [1:0]  KF_FULL = 2'b11;
  localparam logic [1:0]  KF_DATA = 2'b00;

  // identifier nibbles in the top of header / trailer words
  localparam logic [3:0]  HDR_H1  = 4'hA;
  localparam logic [3:0]  HDR_H2  = 4'hB;
  localparam logic [3:0]  HDR_H3  = 4'hC;
  localparam logic [3:0]  HDR_TRL = 4'hE;

  // CRC-16-CCITT, MSB first, no reflection, no final xor
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Each state names the word currently presented on DOUT
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SOF,
    ST_H1,
    ST_H2,
    ST_H3,
    ST_DATA,
    ST_CRC,
    ST_TRL,
    ST_EOF,
    ST_GAP
  } fmt_state_t;

endpackage

// File: rtl/crc16_ccitt_w16.sv
// -----------------------------------------------------------------------------
// crc16_ccitt_w16
// Combinational next-state of a CRC-16-CCITT register after absorbing one
// 16-bit word, MSB first.
// Ports:
//   crc      in  16  current CRC register value
//   data     in  16  word being absorbed
//   crc_next out 16  CRC register value after the word
// Only instantiated when DAQFMT_CRC_EN is defined.
// -----------------------------------------------------------------------------
module crc16_ccitt_w16
  import daq_fmt_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [15:0] data,
  output logic [15:0] crc_next
);

  // Sixteen serial LFSR steps unrolled; data bit 15 enters first
  always_comb begin
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    crc_next = c;
  end

endmodule

// File: rtl/daq_frame_formatter.sv
// -----------------------------------------------------------------------------
// daq_frame_formatter
// Reads complete events (NSAMP*NGRP words of 192 bits) from the upstream
// channel FIFO and serialises each one as a framed stream of 16-bit words:
//   SOF, H1 {A,BOARD_ID}, H2 {B,L1A[23:12]}, H3 {C,L1A[11:0]},
//   data sub-words, [CRC], TRL {E,word count}, EOF, then GAP_CYC fillers.
// Outside frames comma filler 16'h50BC is sent. TX_RDY=0 freezes the stream.
// Ports:
//   CLK       in   1    clock
//   RST       in   1    synchronous active-high reset
//   EVT_AVAIL in   1    FIFO holds at least one complete event
//   FIFO_DIN  in   192  FIFO read data, valid the cycle after RDFIFO
//   RDFIFO    out  1    FIFO read strobe, one pulse per word
//   TX_RDY    in   1    downstream accepts DOUT this cycle
//   DOUT      out  16   output word
//   DOUT_K    out  2    K flags for DOUT high / low byte
//   FRM_ACT   out  1    high from SOF through EOF
//   L1A_CNT   out  24   frames started since reset
// Build option: define DAQFMT_CRC_EN to insert a CRC-16-CCITT word (covering
// H1 through the last data word) between the data and the trailer.
// -----------------------------------------------------------------------------
module daq_frame_formatter
  import daq_fmt_pkg::*;
#(
  parameter int          NSAMP    = 8,
  parameter int          NGRP     = 6,
  parameter logic [11:0] BOARD_ID = 12'h000,
  parameter int          GAP_CYC  = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EVT_AVAIL,
  input  logic [191:0] FIFO_DIN,
  output logic         RDFIFO,
  input  logic         TX_RDY,
  output logic [15:0]  DOUT,
  output logic [1:0]   DOUT_K,
  output logic         FRM_ACT,
  output logic [23:0]  L1A_CNT
);

  localparam int             NWORDS    = NSAMP * NGRP;
  localparam int             NSUB      = 12;
  localparam int             WCW       = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int             GW        = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NWORDS - 1);
  localparam logic [11:0]    DATA_CNT  = 12'(NWORDS * NSUB);
  localparam logic [GW-1:0]  GAP_LOAD  = GW'((GAP_CYC > 1) ? (GAP_CYC - 2) : 0);

  fmt_state_t      state;
  logic [15:0]     dout_q;
  logic [1:0]      k_q;
  logic            frm_q;
  logic [23:0]     l1a_q;
  logic [191:0]    shift_q;
  logic [191:0]    hold_q;
  logic            rd_dly;
  logic [3:0]      sub_idx;
  logic [WCW-1:0]  word_idx;
  logic [GW-1:0]   gap_left;
  logic [191:0]    next_word;

  assign DOUT    = dout_q;
  assign DOUT_K  = k_q;
  assign FRM_ACT = frm_q;
  assign L1A_CNT = l1a_q;

  // Read strobe is decoded from the registered state and qualified by TX_RDY,
  // so a read only happens on the cycle the state machine actually advances:
  // the first word is requested while SOF is accepted, each following word
  // while sub-word 10 of the previous one is accepted.
  assign RDFIFO = TX_RDY &&
                  ((state == ST_SOF) ||
                   ((state == ST_DATA) && (sub_idx == 4'd10) && (word_idx != LAST_WORD)));

  // A prefetched word can be needed on the same edge that would capture it
  // into the hold register, so the FIFO bus is forwarded directly then.
  assign next_word = rd_dly ? FIFO_DIN : hold_q;

  // Hold register follows the FIFO read latency and ignores backpressure:
  // the FIFO presents data exactly one cycle after the strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_dly <= 1'b0;
      hold_q <= '0;
    end else begin
      rd_dly <= RDFIFO;
      if (rd_dly) begin
        hold_q <= FIFO_DIN;
      end
    end
  end

`ifdef DAQFMT_CRC_EN
  logic [15:0] crc_q;
  logic [15:0] crc_next;

  crc16_ccitt_w16 u_crc (
    .crc      (crc_q),
    .data     (dout_q),
    .crc_next (crc_next)
  );

  // Seed on frame start, then absorb every accepted H1..data word
  always_ff @(posedge CLK) begin
    if (RST) begin
      crc_q <= CRC_INIT;
    end else if (TX_RDY) begin
      case (state)
        ST_SOF:                         crc_q <= CRC_INIT;
        ST_H1, ST_H2, ST_H3, ST_DATA:   crc_q <= crc_next;
        default:                        crc_q <= crc_q;
      endcase
    end
  end
`endif

  // Framing FSM: one step per accepted word; each branch loads the word that
  // the next state presents, so DOUT/DOUT_K/FRM_ACT are all registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      dout_q   <= K_IDLE;
      k_q      <= KF_IDLE;
      frm_q    <= 1'b0;
      l1a_q    <= '0;
      shift_q  <= '0;
      sub_idx  <= '0;
      word_idx <= '0;
      gap_left <= '0;
    end else if (TX_RDY) begin
      case (state)
        ST_IDLE: begin
          if (EVT_AVAIL) begin
            state  <= ST_SOF;
            dout_q <= K_SOF;
            k_q    <= KF_FULL;
            frm_q  <= 1'b1;
            l1a_q  <= l1a_q + 24'd1;
          end
        end
        ST_SOF: begin
          state  <= ST_H1;
          dout_q <= {HDR_H1, BOARD_ID};
          k_q    <= KF_DATA;
        end
        ST_H1: begin
          state  <= ST_H2;
          dout_q <= {HDR_H2, l1a_q[23:12]};
        end
        ST_H2: begin
          state  <= ST_H3;
          dout_q <= {HDR_H3, l1a_q[11:0]};
        end
        ST_H3: begin
          state    <= ST_DATA;
          shift_q  <= next_word;
          dout_q   <= next_word[15:0];
          sub_idx  <= '0;
          word_idx <= '0;
        end
        ST_DATA: begin
          if (sub_idx != 4'(NSUB - 1)) begin
            shift_q <= shift_q >> 16;
            dout_q  <= shift_q[31:16];
            sub_idx <= sub_idx + 4'd1;
          end else if (word_idx == LAST_WORD) begin
`ifdef DAQFMT_CRC_EN
            state  <= ST_CRC;
            dout_q <= crc_next;
`else
            state  <= ST_TRL;
            dout_q <= {HDR_TRL, DATA_CNT};
`endif
          end else begin
            shift_q  <= next_word;
            dout_q   <= next_word[15:0];
            sub_idx  <= '0;
            word_idx <= word_idx + WCW'(1);
          end
        end
        ST_CRC: begin
          state  <= ST_TRL;
          dout_q <= {HDR_TRL, DATA_CNT};
        end
        ST_TRL: begin
          state  <= ST_EOF;
          dout_q <= K_EOF;
          k_q    <= KF_FULL;
        end
        ST_EOF: begin
          // The IDLE cycle that launches the next SOF is the last filler of
          // the gap, so GAP itself presents GAP_CYC-1 fillers.
          dout_q   <= K_IDLE;
          k_q      <= KF_IDLE;
          frm_q    <= 1'b0;
          gap_left <= GAP_LOAD;
          state    <= (GAP_CYC > 1) ? ST_GAP : ST_IDLE;
        end
        ST_GAP: begin
          if (gap_left == '0) begin
            state <= ST_IDLE;
          end else begin
            gap_left <= gap_left - GW'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          dout_q <= K_IDLE;
          k_q    <= KF_IDLE;
          frm_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_daq_frame_formatter.sv
// -----------------------------------------------------------------------------
// tb_daq_frame_formatter
// Scoreboard bench for daq_frame_formatter. Stimulus tasks push the expected
// frame words into a queue before releasing an event; an independent negedge
// monitor pops and compares every word the DUT presents with TX_RDY high.
// A second instance with NSAMP=1 covers the short-frame trailer placement.
// Honours DAQFMT_CRC_EN for the expected frame layout.
// -----------------------------------------------------------------------------
module tb_daq_frame_formatter;

  localparam int NW       = 48;
  localparam int GAP_CYC  = 4;
  localparam int LIMIT    = 20000;
`ifdef DAQFMT_CRC_EN
  localparam int SHORT_LEN = 79;
`else
  localparam int SHORT_LEN = 78;
`endif

  typedef struct {
    logic [15:0] w;
    logic [1:0]  k;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         EVT_AVAIL = 1'b0;
  logic [191:0] FIFO_DIN;
  logic         RDFIFO;
  logic         TX_RDY = 1'b1;
  logic [15:0]  DOUT;
  logic [1:0]   DOUT_K;
  logic         FRM_ACT;
  logic [23:0]  L1A_CNT;

  logic         evt1 = 1'b0;
  logic [191:0] din1;
  logic         rd1;
  logic [15:0]  dout1;
  logic [1:0]   k1;
  logic         frm1;
  logic [23:0]  l1a1;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rd_ptr;
  logic [31:0] rd1_ptr;
  logic [23:0] tb_l1a = '0;
  int          tb_base = 0;
  bit          gap_check = 1'b0;
  int          gap_sofs = 0;
  int          fill_cnt = 0;
  logic        prev_rdy = 1'b1;
  logic        prev_rst = 1'b1;
  logic [15:0] prev_dout = '0;
  logic [1:0]  prev_k = '0;

  always #5 CLK = ~CLK;

  daq_frame_formatter #(.NSAMP(8), .NGRP(6), .BOARD_ID(12'h000), .GAP_CYC(GAP_CYC)) u_dut (
    .CLK(CLK), .RST(RST), .EVT_AVAIL(EVT_AVAIL), .FIFO_DIN(FIFO_DIN), .RDFIFO(RDFIFO),
    .TX_RDY(TX_RDY), .DOUT(DOUT), .DOUT_K(DOUT_K), .FRM_ACT(FRM_ACT), .L1A_CNT(L1A_CNT)
  );

  daq_frame_formatter #(.NSAMP(1), .NGRP(6), .BOARD_ID(12'h000), .GAP_CYC(GAP_CYC)) u_dut1 (
    .CLK(CLK), .RST(RST), .EVT_AVAIL(evt1), .FIFO_DIN(din1), .RDFIFO(rd1),
    .TX_RDY(1'b1), .DOUT(dout1), .DOUT_K(k1), .FRM_ACT(frm1), .L1A_CNT(l1a1)
  );

  // FIFO models: word i = {16{i[11:0]}}, one cycle read latency
  always @(posedge CLK) begin
    if (RST) begin
      rd_ptr   <= '0;
      FIFO_DIN <= '0;
    end else if (RDFIFO) begin
      FIFO_DIN <= {16{rd_ptr[11:0]}};
      rd_ptr   <= rd_ptr + 1;
    end
  end

  always @(posedge CLK) begin
    if (RST) begin
      rd1_ptr <= '0;
      din1    <= '0;
    end else if (rd1) begin
      din1    <= {16{rd1_ptr[11:0]}};
      rd1_ptr <= rd1_ptr + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crcStep(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] subWord(input int idx, input int k);
    logic [11:0]  v;
    logic [191:0] w;
    v = idx[11:0];
    w = {16{v}};
    return w[16*k +: 16];
  endfunction

  task automatic pushWord(input logic [15:0] w, input logic [1:0] k);
    exp_t e;
    e.w = w;
    e.k = k;
    sb_q.push_back(e);
  endtask

  task automatic pushFrame(input logic [23:0] l1a, input int base);
    logic [15:0] c;
    logic [15:0] w;
    c = 16'hFFFF;
    pushWord(16'hFBFB, 2'b11);
    w = 16'hA000;               pushWord(w, 2'b00); c = crcStep(c, w);
    w = {4'hB, l1a[23:12]};     pushWord(w, 2'b00); c = crcStep(c, w);
    w = {4'hC, l1a[11:0]};      pushWord(w, 2'b00); c = crcStep(c, w);
    for (int i = 0; i < NW; i++) begin
      for (int k = 0; k < 12; k++) begin
        w = subWord(base + i, k);
        pushWord(w, 2'b00);
        c = crcStep(c, w);
      end
    end
`ifdef DAQFMT_CRC_EN
    pushWord(c, 2'b00);
`endif
    pushWord(16'hE240, 2'b00);
    pushWord(16'hFDFD, 2'b11);
  endtask

  task automatic resetDut();
    RST = 1'b1;
    EVT_AVAIL = 1'b0;
    TX_RDY = 1'b1;
    evt1 = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    sb_q.delete();
    tb_l1a = '0;
    tb_base = 0;
    @(negedge CLK);
    checkOutput("rst_dout", {14'd0, DOUT_K, DOUT}, {14'd0, 2'b01, 16'h50BC});
    checkOutput("rst_frm_act", {31'd0, FRM_ACT}, 32'd0);
    checkOutput("rst_l1a", {8'd0, L1A_CNT}, 32'd0);
    checkOutput("rst_rdfifo", {31'd0, RDFIFO}, 32'd0);
  endtask

  // Queue n_ev frames, raise EVT_AVAIL until the last one has started, and
  // keep driving TX_RDY until the scoreboard has consumed every word.
  task automatic applyStimulus(input int n_ev, input bit rand_rdy);
    logic [23:0] target;
    int cyc;
    for (int e = 0; e < n_ev; e++) begin
      tb_l1a = tb_l1a + 24'd1;
      pushFrame(tb_l1a, tb_base);
      tb_base += NW;
    end
    target = tb_l1a;
    @(posedge CLK);
    #1;
    EVT_AVAIL = 1'b1;
    TX_RDY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 0;
    while ((sb_q.size() != 0 || EVT_AVAIL) && cyc < LIMIT) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (L1A_CNT == target) EVT_AVAIL = 1'b0;
      TX_RDY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    EVT_AVAIL = 1'b0;
    TX_RDY = 1'b1;
    checkOutput("stim_timeout", {31'd0, (cyc < LIMIT)}, 32'd1);
    repeat (GAP_CYC + 4) @(posedge CLK);
    #1;
    checkOutput("queue_drained", sb_q.size(), 32'd0);
    checkOutput("rdfifo_pulses", rd_ptr, tb_base);
    checkOutput("l1a_cnt", {8'd0, L1A_CNT}, {8'd0, tb_l1a});
  endtask

  task automatic runMidFrameReset();
    int cyc;
    tb_l1a = tb_l1a + 24'd1;
    pushFrame(tb_l1a, tb_base);
    @(posedge CLK);
    #1;
    EVT_AVAIL = 1'b1;
    TX_RDY = 1'b1;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (!FRM_ACT && cyc < LIMIT);
    checkOutput("mid_sof_timeout", {31'd0, FRM_ACT}, 32'd1);
    EVT_AVAIL = 1'b0;
    repeat (104) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    sb_q.delete();
    tb_l1a = '0;
    tb_base = 0;
    @(negedge CLK);
    checkOutput("midrst_dout", {16'd0, DOUT}, 32'h50BC);
    checkOutput("midrst_frm_act", {31'd0, FRM_ACT}, 32'd0);
    checkOutput("midrst_l1a", {8'd0, L1A_CNT}, 32'd0);
    applyStimulus(1, 1'b0);
  endtask

  task automatic runShortFrame();
    logic [15:0] words[$];
    logic [15:0] c;
    bit started;
    int cyc;
    started = 1'b0;
    cyc = 0;
    evt1 = 1'b1;
    while (cyc < 1000) begin
      @(negedge CLK);
      cyc++;
      if (frm1) begin
        words.push_back(dout1);
        started = 1'b1;
        evt1 = 1'b0;
      end else if (started) begin
        break;
      end
    end
    evt1 = 1'b0;
    checkOutput("short_len", words.size(), SHORT_LEN);
    checkOutput("short_h3", {16'd0, words[3]}, 32'hC001);
    checkOutput("short_last_data", {16'd0, words[75]}, {16'd0, subWord(5, 11)});
    checkOutput("short_trl", {16'd0, words[SHORT_LEN-2]}, 32'hE048);
    checkOutput("short_eof", {16'd0, words[SHORT_LEN-1]}, 32'hFDFD);
`ifdef DAQFMT_CRC_EN
    c = 16'hFFFF;
    c = crcStep(c, 16'hA000);
    c = crcStep(c, 16'hB000);
    c = crcStep(c, 16'hC001);
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < 12; k++)
        c = crcStep(c, subWord(i, k));
    checkOutput("short_crc", {16'd0, words[76]}, {16'd0, c});
`else
    c = 16'h0;
    checkOutput("short_after_data", {16'd0, words[76]}, {16'd0, c | 16'hE048});
`endif
    checkOutput("short_reads", rd1_ptr, 32'd6);
  endtask

  // Monitor: every accepted word is either scoreboard-checked frame content
  // or checked filler; also watches read gating, stall stability and gaps.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      checkOutput("rdfifo_gating", {31'd0, RDFIFO & (~FRM_ACT | ~TX_RDY)}, 32'd0);
      if (!prev_rdy && !prev_rst)
        checkOutput("stall_hold", {14'd0, DOUT_K, DOUT}, {14'd0, prev_k, prev_dout});
      if (TX_RDY) begin
        if (FRM_ACT) begin
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_word", {14'd0, DOUT_K, DOUT}, 32'hFFFF_FFFF);
          end else begin
            e = sb_q.pop_front();
            checkOutput("frame_word", {14'd0, DOUT_K, DOUT}, {14'd0, e.k, e.w});
          end
          if (DOUT_K == 2'b11 && DOUT == 16'hFDFD) fill_cnt = 0;
          if (DOUT_K == 2'b11 && DOUT == 16'hFBFB && gap_check) begin
            if (gap_sofs > 0) checkOutput("gap_fill", fill_cnt, GAP_CYC);
            gap_sofs++;
          end
        end else begin
          checkOutput("filler", {14'd0, DOUT_K, DOUT}, {14'd0, 2'b01, 16'h50BC});
          fill_cnt++;
        end
      end
    end
    if (!gap_check) gap_sofs = 0;
    prev_rdy  = TX_RDY;
    prev_rst  = RST;
    prev_dout = DOUT;
    prev_k    = DOUT_K;
  end

  initial begin
    $display("[TB] start");
    resetDut();

    $display("[TB] idle filler");
    repeat (100) @(posedge CLK);
    #1;
    checkOutput("idle_reads", rd_ptr, 32'd0);

    $display("[TB] single event, TX_RDY high");
    applyStimulus(1, 1'b0);

    $display("[TB] single event, random backpressure");
    resetDut();
    applyStimulus(1, 1'b1);

    $display("[TB] three back-to-back events");
    resetDut();
    gap_check = 1'b1;
    applyStimulus(3, 1'b0);
    gap_check = 1'b0;

    $display("[TB] reset in mid-frame");
    runMidFrameReset();

    $display("[TB] short frame, NSAMP=1");
    runShortFrame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
